// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo definitions used by the CDB arbiter and the reservation
// stations: result-source count, tag and data widths, the "no producer" tag,
// and a small modulo-increment helper for round-robin pointers.
package cdb_arbiter_pkg;

  localparam int NUM_SRC = 3;   // 0 = add/sub, 1 = logic, 2 = load
  localparam int TAG_W   = 3;   // reservation-station tag width
  localparam int DATA_W  = 16;  // result value width

  // Tag value meaning "operand has no pending producer".
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  // Next index after idx, wrapping from n-1 back to 0.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_grant.sv
// Round-robin grant selection for the CDB arbiter. Purely combinational.
// Ports:
//   full   : per-source holding-slot occupancy
//   rr_ptr : index at which the priority search starts
//   grant  : one-hot grant to the first full slot at or after rr_ptr
//            (modulo NUM_SRC), or zero when no slot is full
module rr_grant
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = cdb_arbiter_pkg::NUM_SRC,
  parameter int PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] full,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_SRC-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    // NOTE: every variable written here is given a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (full[idx] && !found) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter. Each functional-unit source hands its result into
// a one-entry holding slot; full slots are granted round-robin and the winner
// is broadcast on the registered CDB outputs one cycle later.
// Ports:
//   Clock, Reset : clock and synchronous active-high reset
//   Req          : per-source "result available"
//   Tag_In       : per-source producing tag, source i at [i*TAG_W +: TAG_W]
//   Value_In     : per-source result, source i at [i*DATA_W +: DATA_W]
//   Ready        : per-source "slot can accept this cycle" (empty or draining)
//   Cdb_Valid    : one-cycle broadcast strobe
//   Cdb_Tag      : broadcast tag
//   Cdb_Value    : broadcast value
//   Tag_Error    : sticky, set when a handover carries the no-producer tag
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = cdb_arbiter_pkg::NUM_SRC,
  parameter int TAG_W   = cdb_arbiter_pkg::TAG_W,
  parameter int DATA_W  = cdb_arbiter_pkg::DATA_W
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [NUM_SRC-1:0]        Req,
  input  logic [NUM_SRC*TAG_W-1:0]  Tag_In,
  input  logic [NUM_SRC*DATA_W-1:0] Value_In,
  output logic [NUM_SRC-1:0]        Ready,
  output logic                      Cdb_Valid,
  output logic [TAG_W-1:0]          Cdb_Tag,
  output logic [DATA_W-1:0]         Cdb_Value,
  output logic                      Tag_Error
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] full_q,     full_d;
  logic [TAG_W-1:0]   slot_tag_q [NUM_SRC];
  logic [TAG_W-1:0]   slot_tag_d [NUM_SRC];
  logic [DATA_W-1:0]  slot_val_q [NUM_SRC];
  logic [DATA_W-1:0]  slot_val_d [NUM_SRC];
  logic [PTR_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q,  cdb_tag_d;
  logic [DATA_W-1:0]  cdb_value_q, cdb_value_d;
  logic               tag_error_q, tag_error_d;

  logic [NUM_SRC-1:0] grant;
  logic [TAG_W-1:0]   in_tag;

  rr_grant #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_rr_grant (
    .full   (full_q),
    .rr_ptr (rr_ptr_q),
    .grant  (grant)
  );

  // A slot being drained this cycle can take a new entry at the same edge.
  assign Ready = ~full_q | grant;

  always_comb begin
    full_d      = full_q;
    slot_tag_d  = slot_tag_q;
    slot_val_d  = slot_val_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;    // bus holds its last value when idle
    cdb_value_d = cdb_value_q;
    tag_error_d = tag_error_q;
    in_tag      = '0;

    // Drain: at most one grant bit is set.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = slot_tag_q[i];
        cdb_value_d = slot_val_q[i];
        full_d[i]   = 1'b0;
        rr_ptr_d    = PTR_W'(next_idx(i, NUM_SRC));
      end
    end

    // Fill: evaluated after the drain so a refill of a granted slot wins over
    // its clear, keeping the new entry while the old one is broadcast.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (Req[i] && Ready[i]) begin
        in_tag = Tag_In[i*TAG_W +: TAG_W];
        if (in_tag == TAG_W'(NO_TAG)) begin
          // Consumed but never stored, so it can never reach the bus.
          tag_error_d = 1'b1;
        end else begin
          full_d[i]     = 1'b1;
          slot_tag_d[i] = in_tag;
          slot_val_d[i] = Value_In[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      full_q      <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      tag_error_q <= 1'b0;
      // NOTE: slot contents are cleared too, not just the Full bits, so the
      // storage never carries a stale entry out of reset.
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_tag_q[i] <= '0;
        slot_val_q[i] <= '0;
      end
    end else begin
      full_q      <= full_d;
      slot_tag_q  <= slot_tag_d;
      slot_val_q  <= slot_val_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      tag_error_q <= tag_error_d;
    end
  end

  assign Cdb_Valid = cdb_valid_q;
  assign Cdb_Tag   = cdb_tag_q;
  assign Cdb_Value = cdb_value_q;
  assign Tag_Error = tag_error_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by a
// randomized phase, all compared against a behavioural model of the arbiter.
module tb_cdb_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [2:0]  Req;
  logic [8:0]  Tag_In;
  logic [47:0] Value_In;
  logic [2:0]  Ready;
  logic        Cdb_Valid;
  logic [2:0]  Cdb_Tag;
  logic [15:0] Cdb_Value;
  logic        Tag_Error;

  cdb_arbiter dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Req       (Req),
    .Tag_In    (Tag_In),
    .Value_In  (Value_In),
    .Ready     (Ready),
    .Cdb_Valid (Cdb_Valid),
    .Cdb_Tag   (Cdb_Tag),
    .Cdb_Value (Cdb_Value),
    .Tag_Error (Tag_Error)
  );

  always #5 Clock = ~Clock;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: each source has a pending entry or none; the bus
  // carries whichever pending entry the round-robin search finds first.
  bit m_init = 0;
  bit m_full [3];
  int m_tag  [3];
  int m_val  [3];
  int m_ptr;
  bit m_valid;
  int m_ctag, m_cval;
  bit m_err;

  // Observed-broadcast statistics.
  int cyc        = 0;
  int bcast_cnt  [8];
  int bcast_cyc  [8];
  int bcast_total;
  int zero_bcast = 0;

  task automatic check(input string name, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int model_grant();
    int g = -1;
    for (int k = 0; k < 3; k++) begin
      int i = (m_ptr + k) % 3;
      if (g < 0 && m_full[i]) g = i;
    end
    return g;
  endfunction

  function automatic logic [2:0] model_ready();
    logic [2:0] r;
    int g = model_grant();
    for (int i = 0; i < 3; i++) r[i] = !m_full[i] || (g == i);
    return r;
  endfunction

  task automatic model_edge(input logic [2:0] r, input logic [8:0] t,
                            input logic [47:0] v, input logic rs);
    int g;
    logic [2:0] rdy;
    if (rs) begin
      for (int i = 0; i < 3; i++) begin m_full[i] = 0; m_tag[i] = 0; m_val[i] = 0; end
      m_ptr = 0; m_valid = 0; m_ctag = 0; m_cval = 0; m_err = 0; m_init = 1;
      return;
    end
    g   = model_grant();
    rdy = model_ready();
    if (g >= 0) begin
      m_valid = 1; m_ctag = m_tag[g]; m_cval = m_val[g];
      m_full[g] = 0; m_ptr = (g + 1) % 3;
    end else begin
      m_valid = 0;
    end
    for (int i = 0; i < 3; i++) begin
      if (r[i] && rdy[i]) begin
        if (t[i*3 +: 3] == 3'd0) m_err = 1;
        else begin
          m_full[i] = 1; m_tag[i] = int'(t[i*3 +: 3]); m_val[i] = int'(v[i*16 +: 16]);
        end
      end
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 8; i++) begin bcast_cnt[i] = 0; bcast_cyc[i] = -1; end
    bcast_total = 0;
  endtask

  // One clock: drive inputs, check Ready before the edge, then check the
  // registered outputs 1 time unit after the edge.
  task automatic cycle(input logic [2:0] r, input logic [8:0] t,
                       input logic [47:0] v, input logic rs);
    Req = r; Tag_In = t; Value_In = v; Reset = rs;
    #1;
    if (m_init) check("ready", 48'(Ready), 48'(model_ready()));
    @(posedge Clock); #1;
    model_edge(r, t, v, rs);
    cyc++;
    check("cdb_valid", 48'(Cdb_Valid), 48'(m_valid));
    check("cdb_tag",   48'(Cdb_Tag),   48'(m_ctag));
    check("cdb_value", 48'(Cdb_Value), 48'(m_cval));
    check("tag_error", 48'(Tag_Error), 48'(m_err));
    if (Cdb_Valid === 1'b1) begin
      bcast_cnt[Cdb_Tag]++;
      bcast_cyc[Cdb_Tag] = cyc;
      bcast_total++;
      if (Cdb_Tag == 3'd0) zero_bcast++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(3'b000, 9'd0, 48'd0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(3'b000, 9'd0, 48'd0, 1'b1);
    cycle(3'b000, 9'd0, 48'd0, 1'b1);
  endtask

  initial begin
    logic [2:0]  s_req;
    logic [8:0]  s_tag;
    logic [47:0] s_val;
    logic [2:0]  rdy;
    int nt;

    clear_stats();

    // Reset state.
    do_reset();
    check("rst_valid", 48'(Cdb_Valid), 48'd0);
    check("rst_tag",   48'(Cdb_Tag),   48'd0);
    check("rst_value", 48'(Cdb_Value), 48'd0);
    check("rst_err",   48'(Tag_Error), 48'd0);
    Reset = 1'b0; #1;
    check("rst_ready", 48'(Ready), 48'h7);

    // Single result, two-edge latency.
    cycle(3'b001, {3'd0, 3'd0, 3'd3}, {16'h0, 16'h0, 16'h00A5}, 1'b0);
    check("single_not_yet", 48'(Cdb_Valid), 48'd0);
    idle(1);
    check("single_valid", 48'(Cdb_Valid), 48'd1);
    check("single_tag",   48'(Cdb_Tag),   48'd3);
    check("single_value", 48'(Cdb_Value), 48'h00A5);
    idle(1);
    check("single_low", 48'(Cdb_Valid), 48'd0);
    check("single_hold", 48'(Cdb_Tag), 48'd3);

    // Contention: three sources at once, served 1, 2, 3.
    do_reset();
    cycle(3'b111, {3'd3, 3'd2, 3'd1}, {16'h0033, 16'h0022, 16'h0011}, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      idle(1);
      check("cont_valid", 48'(Cdb_Valid), 48'd1);
      check("cont_tag",   48'(Cdb_Tag),   48'(k));
      check("cont_value", 48'(Cdb_Value), 48'(k * 16'h0011));
    end
    check("cont_ptr", 48'(dut.rr_ptr_q), 48'd0);

    // Back-pressure: source 0 streams tags 4..6 against two busy sources.
    do_reset();
    clear_stats();
    cycle(3'b111, {3'd2, 3'd1, 3'd4}, {16'h0222, 16'h0111, 16'h0444}, 1'b0);
    nt = 5;
    for (int k = 0; k < 10; k++) begin
      rdy   = model_ready();
      s_req = {2'b11, (nt <= 6) ? 1'b1 : 1'b0};
      cycle(s_req, {3'd2, 3'd1, 3'(nt)}, {16'h0222, 16'h0111, 16'(nt * 16'h0111)}, 1'b0);
      if (s_req[0] && rdy[0]) nt++;
    end
    idle(4);
    check("bp_cnt4", 48'(bcast_cnt[4]), 48'd1);
    check("bp_cnt5", 48'(bcast_cnt[5]), 48'd1);
    check("bp_cnt6", 48'(bcast_cnt[6]), 48'd1);
    check("bp_gap45", 48'(bcast_cyc[5] - bcast_cyc[4]), 48'd3);
    check("bp_gap56", 48'(bcast_cyc[6] - bcast_cyc[5]), 48'd3);

    // Drain plus refill of slot 2 at the same edge.
    do_reset();
    clear_stats();
    cycle(3'b100, {3'd5, 3'd0, 3'd0}, {16'h0555, 16'h0, 16'h0}, 1'b0);
    check("dr_ready2", 48'(Ready[2]), 48'd1);
    cycle(3'b100, {3'd7, 3'd0, 3'd0}, {16'h0777, 16'h0, 16'h0}, 1'b0);
    check("dr_old_tag", 48'(Cdb_Tag), 48'd5);
    idle(1);
    check("dr_new_tag", 48'(Cdb_Tag), 48'd7);
    check("dr_new_val", 48'(Cdb_Value), 48'h0777);
    idle(3);
    check("dr_cnt7", 48'(bcast_cnt[7]), 48'd1);

    // Tag 0 handover sets the sticky error and is never broadcast.
    cycle(3'b010, {3'd0, 3'd0, 3'd0}, {16'h0, 16'hFFFF, 16'h0}, 1'b0);
    check("t0_err", 48'(Tag_Error), 48'd1);
    idle(3);
    check("t0_sticky", 48'(Tag_Error), 48'd1);
    check("t0_novalid", 48'(Cdb_Valid), 48'd0);

    // Reset mid-stream with all slots full.
    do_reset();
    cycle(3'b111, {3'd3, 3'd2, 3'd1}, {16'h0033, 16'h0022, 16'h0011}, 1'b0);
    cycle(3'b000, 9'd0, 48'd0, 1'b1);
    check("mid_rst_valid", 48'(Cdb_Valid), 48'd0);
    check("mid_rst_ready", 48'(Ready), 48'h7);
    clear_stats();
    idle(4);
    check("mid_rst_stale", 48'(bcast_total), 48'd0);

    // Randomized traffic; sources hold their offer until it is accepted.
    s_req = '0; s_tag = '0; s_val = '0;
    for (int k = 0; k < 400; k++) begin
      logic rs;
      rdy = model_ready();
      rs  = ($urandom_range(0, 63) == 0);
      cycle(s_req, s_tag, s_val, rs);
      for (int i = 0; i < 3; i++) begin
        if (!s_req[i] || (rdy[i] && !rs)) begin
          s_req[i] = ($urandom_range(0, 3) != 0);
          s_tag[i*3 +: 3]  = ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
          s_val[i*16 +: 16] = 16'($urandom);
        end
      end
    end
    idle(4);
    check("no_tag0_bcast", 48'(zero_bcast), 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_SRC, 3, number of functional-unit result sources (0 = add/sub, 1 = logic, 2 = load).
REQ-002 Parameter TAG_W, 3, reservation-station tag width; tag 0 means "no producer".
REQ-003 Parameter DATA_W, 16, result value width.
REQ-004 Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high; sampled on the rising edge of Clock.
REQ-006 Req  input  NUM_SRC  per-source "result available" request.
REQ-007 Tag_In  input  NUM_SRC*TAG_W  per-source producing-station tag; source i occupies bits [i*TAG_W +: TAG_W].
REQ-008 Value_In  input  NUM_SRC*DATA_W  per-source result value; source i occupies bits [i*DATA_W +: DATA_W].
REQ-009 Ready  output  NUM_SRC  per-source "holding slot can accept this cycle".
REQ-010 Cdb_Valid  output  1  broadcast strobe, high for exactly the cycle in which a result is on the bus.
REQ-011 Cdb_Tag  output  TAG_W  broadcast tag, compared by reservation stations against their Qj/Qk.
REQ-012 Cdb_Value  output  DATA_W  broadcast value, captured into Vj/Vk on a tag match.
REQ-013 Tag_Error  output  1  sticky flag; set when a source hands over a result carrying tag 0.

Function
REQ-014 Each source SHALL own a one-entry holding slot consisting of a Full bit, a tag and a value.
REQ-015 Ready[i] SHALL equal !Full[i] OR Grant[i], where Grant[i] is the current cycle's combinational grant; Ready is therefore high while the slot is empty or is being drained.
REQ-016 A handover SHALL occur at an edge where Req[i] and Ready[i] are both high; the slot then loads Tag_In/Value_In for source i and sets Full[i].
REQ-017 A handover carrying tag 0 SHALL be consumed without filling the slot, SHALL set Tag_Error, and SHALL never be broadcast.
REQ-018 Grant SHALL be one-hot or zero and SHALL be chosen round-robin among the full slots.
REQ-019 The search SHALL start at the pointer Rr_Ptr, range 0..NUM_SRC-1, and proceed Rr_Ptr, Rr_Ptr+1, ... modulo NUM_SRC.
REQ-020 After a grant to source g, Rr_Ptr SHALL become (g+1) mod NUM_SRC, wrapping from NUM_SRC-1 to 0.
REQ-021 With no grant, Rr_Ptr SHALL hold its value.
REQ-022 At an edge with a grant to g, the block SHALL register Cdb_Tag/Cdb_Value from slot g, set Cdb_Valid, and clear Full[g] unless g is refilled at the same edge.
REQ-023 At an edge with no grant, Cdb_Valid SHALL be 0, and Cdb_Tag/Cdb_Value SHALL hold their previous values.
REQ-024 Latency: for a handover at edge k into an empty slot with no contention, Cdb_Valid SHALL be high, with that tag, in the cycle following edge k+1.
REQ-025 Throughput: at most one broadcast per cycle; with all slots continuously full, each source SHALL be granted once every NUM_SRC cycles.
REQ-026 Simultaneous drain and refill of slot i at the same edge SHALL be lossless: the old entry is broadcast and the new entry is held.
REQ-027 When a source is not Ready, its request SHALL be ignored; the source holds Req/Tag/Value until it is Ready.
REQ-028 Duplicate tags from different sources SHALL be broadcast independently; the block SHALL not check for duplicates.

Reset
REQ-029 While Reset is high at an edge: Full = 0, slot contents = 0, Rr_Ptr = 0, Cdb_Valid = 0, Cdb_Tag = 0, Cdb_Value = 0, Tag_Error = 0.
REQ-030 Reset asserted mid-operation SHALL discard all pending slot contents, with no broadcast in the following cycle.
REQ-031 Ready SHALL read all-ones in the first cycle after Reset deasserts.

Structure
REQ-032 TAG_W, DATA_W, NUM_SRC and the constant NO_TAG = 0 SHALL live in the shared Tomasulo package used by the reservation stations.
REQ-033 The round-robin grant logic SHALL be one sub-module, rr_grant (Full vector and Rr_Ptr in, one-hot Grant out, purely combinational).
REQ-034 The holding slots, pointer and CDB output registers SHALL live in cdb_arbiter.

Verification
REQ-035 Single result: Req = 001, tag 3, value 16'h00A5 at edge 1 -> Cdb_Valid high after edge 2 with tag 3 / 16'h00A5, then low.
REQ-036 Contention: all three sources hand over tags 1/2/3 (values 16'h0011/16'h0022/16'h0033) at the same edge after reset -> broadcasts in consecutive cycles in order tag 1, 2, 3; Rr_Ptr ends at 0.
REQ-037 Back-pressure: source 0 holds Req continuously with new tags 4, 5, 6 while sources 1 and 2 are also full -> Ready[0] is low except in its grant cycles; no tag is lost or duplicated; every source is served within 3 cycles.
REQ-038 Drain plus refill: slot 2 is granted in the same cycle that source 2 presents tag 7 -> tag 7 is broadcast exactly once on a later cycle.
REQ-039 Tag 0: source 1 hands over tag 0, value 16'hFFFF -> Tag_Error = 1 and stays 1; Cdb_Valid never shows tag 0.
REQ-040 Reset mid-stream: Reset asserted with all three slots full -> the next cycle shows Cdb_Valid = 0 and Ready = 111, and no stale tag is broadcast afterwards.
